// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB payload layout for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam int MEMWB_W            = 39;
  localparam int MEMWB_HALT_IDX     = 38;
  localparam int MEMWB_REGWRITE_IDX = 37;
  localparam int MEMWB_DSTREG_LSB   = 33;
  localparam int MEMWB_ALUVAL_LSB   = 17;
  localparam int MEMWB_READDATA_LSB = 1;
  localparam int MEMWB_MEMTOREG_IDX = 0;

  function automatic logic [MEMWB_W-1:0] packMemWb(
    input logic        halt,
    input logic        regWrite,
    input logic [3:0]  dstReg,
    input logic [15:0] aluVal,
    input logic [15:0] readData,
    input logic        memtoReg
  );
    return {halt, regWrite, dstReg, aluVal, readData, memtoReg};
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and asynchronous active-low clear.
module pipe_data_reg #(
  parameter int DATA_W = 39
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with flush and sticky halt detection.
// Define PIPE_SKID_EN for the 2-entry skid buffer with state-only in_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = MEMWB_W,
  parameter int HALT_IDX = MEMWB_HALT_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              halted
);

  occ_t              state;
  occ_t              stateNext;
  logic              accept;
  logic              drain;
  logic              headEn;
  logic [DATA_W-1:0] headD;
  logic [DATA_W-1:0] headData_p0;
`ifdef PIPE_SKID_EN
  logic              skidEn;
  logic              headFromSkid;
  logic [DATA_W-1:0] skidData_p0;
`endif

  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = headData_p0;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  assign in_ready = ~halted & (state != OCC_FULL);
  assign headD    = headFromSkid ? skidData_p0 : in_data;
`else
  assign in_ready = ~halted & (~out_valid | out_ready);
  assign headD    = in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Flush wins over everything; held data is simply abandoned, not cleared.
  always_comb begin
    stateNext = state;
    headEn    = 1'b0;
`ifdef PIPE_SKID_EN
    skidEn       = 1'b0;
    headFromSkid = 1'b0;
`endif
    if (flush) begin
      stateNext = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            stateNext = OCC_ONE;
            headEn    = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            headEn = 1'b1;
          end else if (drain) begin
            stateNext = OCC_EMPTY;
`ifdef PIPE_SKID_EN
          end else if (accept) begin
            stateNext = OCC_FULL;
            skidEn    = 1'b1;
`endif
          end
        end
        OCC_FULL: begin
`ifdef PIPE_SKID_EN
          if (drain) begin
            stateNext    = OCC_ONE;
            headEn       = 1'b1;
            headFromSkid = 1'b1;
          end
`else
          stateNext = OCC_EMPTY;
`endif
        end
        default: stateNext = OCC_EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.DATA_W(DATA_W)) uHead (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (headEn),
    .d     (headD),
    .q     (headData_p0)
  );

`ifdef PIPE_SKID_EN
  pipe_data_reg #(.DATA_W(DATA_W)) uSkid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skidEn),
    .d     (in_data),
    .q     (skidData_p0)
  );
`endif

  // A halt beat that leaves the stage latches halted even on a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (drain && out_data[HALT_IDX]) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage; follows PIPE_SKID_EN when defined.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int DW = MEMWB_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          halted;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdlQ[$];
  logic          mdlHalted = 1'b0;

  pipe_skid_stage #(.DATA_W(DW), .HALT_IDX(MEMWB_HALT_IDX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    logic          expRdy;
    logic          expVld;
    logic          acc;
    logic          drn;
    logic [DW-1:0] headV;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
`ifdef PIPE_SKID_EN
    expRdy = !mdlHalted && (mdlQ.size() < 2);
`else
    expRdy = !mdlHalted && (mdlQ.size() == 0 || ordy);
`endif
    expVld = (mdlQ.size() != 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, expRdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, expVld});
    chk("halted", {63'd0, halted}, {63'd0, mdlHalted});
    if (expVld) chk("out_data", 64'(out_data), 64'(mdlQ[0]));
    acc = iv && expRdy;
    drn = expVld && ordy;
    @(posedge clk);
    if (drn) begin
      headV = mdlQ.pop_front();
      if (headV[MEMWB_HALT_IDX]) mdlHalted = 1'b1;
    end
    if (fl) mdlQ.delete();
    else if (acc) mdlQ.push_back(id);
    #1;
  endtask

  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_halted", {63'd0, halted}, 64'd0);
    mdlQ.delete();
    mdlHalted = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] haltBeat;
    haltBeat  = packMemWb(1'b1, 1'b1, 4'h3, 16'h1234, 16'h5678, 1'b0);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure then release.
    step(1'b1, DW'(20'hAAAA), 1'b0, 1'b0);
    step(1'b1, DW'(20'hBBBB), 1'b0, 1'b0);
    step(1'b1, DW'(20'hCCCC), 1'b0, 1'b0);
    chk("bp_hold_head", 64'(out_data), 64'h0AAAA);
    step(1'b1, DW'(20'hCCCC), 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a beat offered on the flush cycle.
    step(1'b1, DW'(1), 1'b0, 1'b0);
    step(1'b1, DW'(2), 1'b0, 1'b0);
    step(1'b1, DW'(3), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_empty", {63'd0, out_valid}, 64'd0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Halt beat drains, later beats refused, flush leaves halted set.
    step(1'b1, haltBeat, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step(1'b1, DW'(5), 1'b1, 1'b0);
    chk("halt_set", {63'd0, halted}, 64'd1);
    chk("halt_blocks", {63'd0, in_ready}, 64'd0);
    step(1'b1, DW'(5), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("halt_sticky", {63'd0, halted}, 64'd1);

    // Async reset clears halted, then again with the stage filled.
    asyncReset();
    step(1'b1, DW'(20'h11111), 1'b0, 1'b0);
    step(1'b1, DW'(20'h22222), 1'b0, 1'b0);
    asyncReset();
    repeat (2) step(1'b1, DW'(7), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
